// File: rtl/lsu_misalign.sv
// Load/store sequencer between execute and data memory.
// Aligned (and illegal-ctrl) accesses pass straight through with no added latency.
// Misaligned halfword/word accesses are split into byte accesses while the core is stalled,
// and load bytes are reassembled and extended on the final byte.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned requests raise misalign_err
// instead of being split.
module lsu_misalign #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic [2:0]        mem_ctrl,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       buf_q, buf_d;

  logic is_half, is_word, misaligned, last_byte, sign_bit;

  // Classify the incoming request; only legal halfword/word codes can be misaligned.
  always_comb begin
    is_half    = (req_ctrl == 3'b001) || (req_ctrl == 3'b101);
    is_word    = (req_ctrl == 3'b010);
    misaligned = req_valid && ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
  end

  // Next-state and output logic for pass-through and byte-split sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    addr_d       = addr_q;
    we_d         = we_q;
    ctrl_d       = ctrl_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_addr     = req_addr;
    mem_wdata    = req_wdata;
    mem_we       = req_valid & req_we;
    mem_ctrl     = req_ctrl;
    stall        = 1'b0;
    rdata_valid  = 1'b0;
    rdata        = 32'h0;
    misalign_err = 1'b0;
    last_byte    = 1'b0;
    sign_bit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (misaligned) begin
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_err = 1'b1;
          mem_we       = 1'b0;
`else
          // Byte 0 goes out this cycle; the rest follow from SPLIT.
          addr_d        = req_addr;
          we_d          = req_we;
          ctrl_d        = req_ctrl;
          wdata_d       = req_wdata;
          nbytes_d      = is_word ? 3'd4 : 3'd2;
          mem_ctrl      = req_we ? 3'b000 : 3'b100;
          mem_wdata     = {24'h0, req_wdata[7:0]};
          mem_we        = req_we;
          stall         = 1'b1;
          buf_d[7:0]    = mem_rdata[7:0];
          cnt_d         = 2'd1;
          state_d       = StSplit;
`endif
        end else begin
          rdata_valid = req_valid & ~req_we;
          rdata       = rdata_valid ? mem_rdata : 32'h0;
        end
      end
      StSplit: begin
        mem_addr  = addr_q + ADDR_W'(cnt_q);
        mem_wdata = {24'h0, wdata_q[8*cnt_q +: 8]};
        mem_ctrl  = we_q ? 3'b000 : 3'b100;
        mem_we    = we_q;
        last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
        if (!last_byte) begin
          stall = 1'b1;
          case (cnt_q)
            2'd1:    buf_d[15:8]  = mem_rdata[7:0];
            2'd2:    buf_d[23:16] = mem_rdata[7:0];
            default: buf_d        = buf_q;
          endcase
          cnt_d = cnt_q + 2'd1;
        end else begin
          state_d = StIdle;
          cnt_d   = 2'd0;
          if (!we_q) begin
            rdata_valid = 1'b1;
            sign_bit    = ~ctrl_q[2] & mem_rdata[7];
            if (nbytes_q == 3'd4) rdata = {mem_rdata[7:0], buf_q};
            else                  rdata = {{16{sign_bit}}, mem_rdata[7:0], buf_q[7:0]};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // While reset is held the core sees an idle, non-committing LSU.
    if (rst) begin
      stall        = 1'b0;
      rdata_valid  = 1'b0;
      rdata        = 32'h0;
      mem_we       = 1'b0;
      misalign_err = 1'b0;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      nbytes_q <= 3'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      ctrl_q   <= 3'b000;
      wdata_q  <= 32'h0;
      buf_q    <= 24'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      ctrl_q   <= ctrl_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: doc/lsu_misalign.md
Name: lsu_misalign

Overview:
Load/store sequencer between the core's execute stage and the data memory. Aligned accesses pass straight through to the data memory in the same cycle. Misaligned halfword and word accesses are split into sequential byte accesses while the core is stalled. Read bytes are reassembled and sign- or zero-extended before being returned to the core.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  core issues a load/store this cycle
req_we  in  1  1 = store, 0 = load
req_ctrl  in  3  access mode: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
stall  out  1  core must hold PC, instruction and operands and not commit
rdata  out  32  load result, extended
rdata_valid  out  1  load result valid; core commits this cycle
misalign_err  out  1  misaligned-access trap pulse (optional feature only)
mem_addr  out  ADDR_W  to data memory Address
mem_wdata  out  32  to data memory DataWr
mem_we  out  1  to data memory DMWr
mem_ctrl  out  3  to data memory DMCtrl
mem_rdata  in  32  from data memory DataRd (combinational read)

Behaviour:
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Bytes and illegal ctrl codes are never misaligned.
- Illegal ctrl codes pass through unchanged; no split is performed.
- States: IDLE, SPLIT. Internal registers: byte count cnt (2 bits), nbytes (2 or 4), captured addr/we/ctrl/wdata, and a 24-bit byte buffer.
- IDLE, aligned or illegal request:
  - mem_* equal the req_* fields (mem_we=req_valid&req_we).
  - rdata=mem_rdata; rdata_valid=req_valid&~req_we; stall=0.
  - Zero added latency.
- IDLE, misaligned request (cycle 0):
  - Capture the request.
  - Issue byte 0: mem_addr=req_addr, mem_ctrl=100 for a load or 000 for a store, mem_wdata={24'b0, wdata[7:0]}.
  - stall=1; buffer[7:0] <= mem_rdata[7:0]; cnt <= 1; go to SPLIT.
- SPLIT, byte k=cnt:
  - mem_addr = captured addr + k (modulo 2^ADDR_W; wrap past all-ones, carry ignored).
  - mem_wdata = {24'b0, wdata byte k}; mem_ctrl as above; mem_we = captured we.
  - Non-final byte: stall=1; buffer byte k <= mem_rdata[7:0]; cnt++.
  - Final byte (k=nbytes-1): stall=0; go to IDLE.
    - Loads: rdata_valid=1; rdata = {mem_rdata[7:0], buffer} truncated to nbytes, sign-extended for ctrl 001/010 and zero-extended for 101.
    - Stores: rdata_valid=0.
- Total cycles: misaligned halfword 2 (stall high 1 cycle); misaligned word 4 (stall high 3 cycles).
- Requests arriving in SPLIT are ignored. The core holds them stable because stall is high.
- rdata=0 whenever rdata_valid=0.
- Reset values: state IDLE, cnt=0, buffer=0, captured fields=0, stall=0, rdata_valid=0, misalign_err=0.
- Reset mid-SPLIT returns to IDLE immediately. Bytes already stored stay in memory; no rollback.
- mem_* outputs in IDLE with req_valid=0: mem_we=0; other mem_* fields follow req_*.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are never split and SPLIT is never entered. misalign_err=1 combinationally in that cycle; mem_we=0; rdata_valid=0; stall=0.
- Undefined: misalign_err is tied 0 and splitting behaves as above.

Test Plan:
Preload mem word0=0x44332211, word1=0x88776655, word2=0x000000AA.
- lw addr 4 -> rdata=0x88776655, rdata_valid same cycle, stall never high.
- lw addr 1 -> stall high 3 cycles; 4th cycle rdata=0x55443322, rdata_valid=1; mem_addr sequence 1,2,3,4.
- lh addr 7 -> 2 cycles, rdata=0xFFFFAA88; lhu addr 7 -> rdata=0x0000AA88.
- sw 0xDEADBEEF addr 2 -> 4 byte writes; afterwards word0=0xBEEF2211, word1=0x8877DEAD.
- lw addr 1 with rst asserted in 2nd cycle -> stall=0, rdata_valid=0 immediately; next aligned lw addr 0 completes normally with 0x44332211.
- With LSU_MISALIGN_TRAP_EN, sh addr 3 -> misalign_err=1 for one cycle, mem_we=0, memory unchanged.
